// File: rtl/screen_scanout.sv
// Hack screen scanout: walks the frame buffer word by word and serialises each 16-bit word LSB first.
// Define SCANOUT_PREFETCH_EN to add a one-word holding buffer so pixels stream without gaps.
module screen_scanout #(
  parameter int WORDS     = 8192,
  parameter int ROW_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [12:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        pix,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sol,
  output logic        sof,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

  localparam logic [12:0] LAST_WORD = 13'(WORDS - 1);
  localparam logic [12:0] ROW_W     = 13'(ROW_WORDS);

  state_t      state_q, state_d;
  logic [12:0] word_q, word_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        done_q, done_d;
  logic        xfer;

`ifdef SCANOUT_PREFETCH_EN
  logic [15:0] buf_q;
  logic        first_q, first_d;
  logic        cap_q;
`endif

  assign xfer = (state_q == SHIFT) && pix_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 13'd0;
      bit_q   <= 4'd0;
      shift_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

`ifdef SCANOUT_PREFETCH_EN
  // Prefetch read is issued in the first SHIFT cycle; data lands one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= 16'd0;
      first_q <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      cap_q   <= (state_q == SHIFT) && mem_rd;
      if (cap_q) buf_q <= mem_rdata;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = 13'd0;
`ifdef SCANOUT_PREFETCH_EN
    first_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = 13'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = word_q;
        state_d  = WAIT;
      end
      WAIT: begin
        shift_d = mem_rdata;
        bit_d   = 4'd0;
        state_d = SHIFT;
`ifdef SCANOUT_PREFETCH_EN
        first_d = 1'b1;
`endif
      end
      SHIFT: begin
`ifdef SCANOUT_PREFETCH_EN
        if (first_q && (word_q != LAST_WORD)) begin
          mem_rd   = 1'b1;
          mem_addr = word_q + 13'd1;
        end
`endif
        if (xfer) begin
          shift_d = {1'b0, shift_q[15:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            if (word_q == LAST_WORD) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              word_d = word_q + 13'd1;
`ifdef SCANOUT_PREFETCH_EN
              shift_d = buf_q;
              first_d = 1'b1;
`else
              state_d = FETCH;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_valid  = (state_q == SHIFT);
  assign pix        = pix_valid && shift_q[0];
  assign sol        = pix_valid && (bit_q == 4'd0) && ((word_q % ROW_W) == 13'd0);
  assign sof        = pix_valid && (bit_q == 4'd0) && (word_q == 13'd0);
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: doc/screen_scanout.md
SCREEN_SCANOUT -- requirements
Module: screen_scanout

Interface
REQ-001 The block SHALL have parameter WORDS, default 8192, meaning words per frame (512x256 Hack screen).
REQ-002 The block SHALL have parameter ROW_WORDS, default 32, meaning words per pixel row.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a one-cycle pulse that begins a frame scan.
REQ-006 The block SHALL have port mem_addr, output, 13, meaning the screen-memory word address.
REQ-007 The block SHALL have port mem_rd, output, 1, meaning the read strobe for mem_addr.
REQ-008 The block SHALL have port mem_rdata, input, 16, meaning the read data, valid on the cycle after mem_rd.
REQ-009 The block SHALL have port pix, output, 1, meaning the current pixel (1 = black).
REQ-010 The block SHALL have port pix_valid, output, 1, meaning pix, sol and sof are valid.
REQ-011 The block SHALL have port pix_ready, input, 1, meaning the sink accepts pix this cycle.
REQ-012 The block SHALL have port sol, output, 1, meaning the current pixel is the first pixel of a row.
REQ-013 The block SHALL have port sof, output, 1, meaning the current pixel is the first pixel of the frame.
REQ-014 The block SHALL have port busy, output, 1, meaning a scan is in progress.
REQ-015 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last pixel is accepted.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, WAIT and SHIFT.
REQ-017 In IDLE, start=1 SHALL clear the word counter to 0, set busy=1 and go to FETCH.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 FETCH SHALL drive mem_addr=word counter and mem_rd=1 for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL load mem_rdata into the 16-bit shift register, clear the bit counter and go to SHIFT.
REQ-021 In SHIFT, pix_valid SHALL be 1 and pix SHALL equal shift-register bit 0, i.e. the Hack LSB-leftmost order.
REQ-022 A transfer SHALL occur only on the cycles where pix_valid=1 and pix_ready=1; each transfer shifts the register right by one and increments the bit counter.
REQ-023 While pix_valid=1 and pix_ready=0, pix, sol and sof SHALL be held stable.
REQ-024 sol SHALL be 1 iff bit counter=0 and (word counter mod ROW_WORDS)=0.
REQ-025 sof SHALL be 1 iff bit counter=0 and word counter=0.
REQ-026 On the 16th transfer of a word that is not the last: the word counter SHALL increment and the FSM SHALL go to FETCH.
REQ-027 On the 16th transfer of word WORDS-1: the FSM SHALL go to IDLE, busy SHALL drop and frame_done SHALL pulse for one cycle.
REQ-028 A start arriving in the frame_done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-029 mem_rd SHALL be 0 outside fetch cycles, and mem_addr SHALL be don't-care when mem_rd=0.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE and clear both counters and the shift register, mid-frame included.
REQ-031 During reset, pix, pix_valid, sol, sof, mem_rd, busy and frame_done SHALL be 0 and mem_addr SHALL be 0.
REQ-032 After reset deasserts, the block SHALL stay in IDLE until a start pulse arrives.

Configuration
REQ-033 With macro SCANOUT_PREFETCH_EN defined, a one-word holding buffer SHALL be used: during the first SHIFT cycle of word n<WORDS-1, the block issues mem_rd for word n+1 and captures the data into the buffer on the following cycle.
REQ-034 With SCANOUT_PREFETCH_EN, the 16th transfer SHALL load the shift register from the buffer and remain in SHIFT, so pix_valid never drops within a frame; FETCH and WAIT occur only for word 0.
REQ-035 Without SCANOUT_PREFETCH_EN, there SHALL be no buffer, and each word SHALL incur a 2-cycle pix_valid=0 gap (FETCH, WAIT).

Verification
REQ-036 Scenario: reset, then start, with pix_ready=1 and memory word 0=0x0001 -> mem_rd at addr 0 on cycle 1; first pix=1 with sof=1 and sol=1 on cycle 3; next 15 pix=0.
REQ-037 Scenario: full frame with pix_ready=1 and mem[i]=i -> 131072 transfers; sol asserted 256 times; frame_done once; busy low afterwards; without prefetch, 2 gap cycles per word; with prefetch, 0 gap cycles after word 0.
REQ-038 Scenario: pix_ready toggling 1,0,0,1 on word 0x8000 -> pix held stable while stalled; bit 15 (=1) emitted on the 16th accepted transfer.
REQ-039 Scenario: start pulsed mid-frame at word 100 -> ignored; the word counter continues to 101.
REQ-040 Scenario: reset asserted at word 4000, bit 7 -> all outputs 0 within the same cycle; a later start restarts at mem_addr 0.
REQ-041 Scenario: start held high in the frame_done cycle -> a new frame begins and mem_rd at addr 0 follows.
